// File: rtl/cfg_pkg.sv
// Shared types and clock-derived defaults for the Si5340 configuration loader path.
`timescale 1ns/1ps
package cfg_pkg;

  localparam int PERIOD_NS  = 8;
  localparam int MEM_DEPTH  = 512;
  localparam int DATA_WIDTH = 8;

  // Settle and timeout budgets expressed in time, converted to clk cycles.
  localparam int SETTLE_MS  = 300;
  localparam int TIMEOUT_US = 8_000;
  localparam int DEFAULT_DELAY_CYCLES   = SETTLE_MS * 1_000_000 / PERIOD_NS;
  localparam int DEFAULT_TIMEOUT_CYCLES = TIMEOUT_US * 1_000 / PERIOD_NS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_SETTLE,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } seq_state_t;

  typedef enum logic {
    PASS_WRITE,
    PASS_VERIFY
  } pass_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/si5340_cfg_sequencer_if.sv
// Load/done handshake between the configuration sequencer (master) and the table loader (slave).
`timescale 1ns/1ps
interface si5340_cfg_sequencer_if #(
  parameter int IDX_W  = $clog2(cfg_pkg::MEM_DEPTH),
  parameter int DATA_W = cfg_pkg::DATA_WIDTH
) ();

  logic              load_o;
  logic              write_o;
  logic [IDX_W-1:0]  entry_idx_o;
  logic              txn_done_i;
  logic [DATA_W-1:0] rd_data_i;
  logic [DATA_W-1:0] exp_data_i;

  modport master (
    output load_o, write_o, entry_idx_o,
    input  txn_done_i, rd_data_i, exp_data_i
  );

  modport slave (
    input  load_o, write_o, entry_idx_o,
    output txn_done_i, rd_data_i, exp_data_i
  );

endinterface

// File: rtl/cfg_cycle_timer.sv
// Clearable up-counter that flags when it reaches a caller-supplied terminal count.
`timescale 1ns/1ps
module cfg_cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] tc_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    // NOTE: count_d takes its hold value first so every path assigns it and no latch is inferred.
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignment so every register samples pre-edge values, whatever the block order.
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && (count_q == tc_i);

endmodule

// File: rtl/si5340_cfg_sequencer.sv
// Walks the Si5340 config table, issuing one loader transaction per entry, with an optional
// readback-verify pass; reports busy/done/timeout/mismatch status upstream.
`timescale 1ns/1ps
module si5340_cfg_sequencer #(
  parameter int NUM_ENTRIES    = cfg_pkg::MEM_DEPTH,
  parameter int PREAMBLE_LEN   = 3,
  parameter int DELAY_CYCLES   = cfg_pkg::DEFAULT_DELAY_CYCLES,
  parameter int TIMEOUT_CYCLES = cfg_pkg::DEFAULT_TIMEOUT_CYCLES,
  parameter int DATA_WIDTH     = cfg_pkg::DATA_WIDTH,
  localparam int IDX_W         = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         verify_i,
  si5340_cfg_sequencer_if.master       bus_if,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         error_o,
  output logic [IDX_W-1:0]             err_idx_o,
  output logic [15:0]                  mismatch_cnt_o
);

  import cfg_pkg::*;

  localparam int TIMER_W = $clog2(max_int(max_int(DELAY_CYCLES, TIMEOUT_CYCLES), 2));
  localparam logic [TIMER_W-1:0] TC_DELAY   = TIMER_W'(DELAY_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TC_TIMEOUT = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_ENTRIES - 1);
  localparam bit                 HAS_SETTLE = (PREAMBLE_LEN > 0);
  localparam logic [IDX_W-1:0]   SETTLE_IDX = IDX_W'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);

  if (PREAMBLE_LEN > NUM_ENTRIES) begin : g_bad_preamble
    $error("PREAMBLE_LEN (%0d) exceeds NUM_ENTRIES (%0d)", PREAMBLE_LEN, NUM_ENTRIES);
  end

  seq_state_t       state_q, state_d;
  pass_t            pass_q, pass_d;
  logic             verify_q, verify_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             load_q, load_d;
  logic             write_q, write_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;
  logic [15:0]      mm_cnt_q, mm_cnt_d;

  logic [DATA_WIDTH-1:0] rd_data, exp_data;
  logic                  timer_clr, timer_en, timer_expired;
  logic [TIMER_W-1:0]    timer_tc;

  assign rd_data  = bus_if.rd_data_i;
  assign exp_data = bus_if.exp_data_i;

  // SETTLE and WAIT_DONE never overlap, so one counter serves both; it restarts on every state change.
  assign timer_en  = (state_q == ST_WAIT_DONE) || (state_q == ST_SETTLE);
  assign timer_tc  = (state_q == ST_SETTLE) ? TC_DELAY : TC_TIMEOUT;
  assign timer_clr = (state_d != state_q);

  cfg_cycle_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (timer_clr),
    .enable_i  (timer_en),
    .tc_i      (timer_tc),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    verify_d  = verify_q;
    idx_d     = idx_q;
    load_d    = 1'b0;
    write_d   = write_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    err_idx_d = err_idx_q;
    mm_cnt_d  = mm_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          verify_d = verify_i;
          pass_d   = PASS_WRITE;
          idx_d    = '0;
          done_d   = 1'b0;
          error_d  = 1'b0;
          mm_cnt_d = '0;
          busy_d   = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        load_d  = 1'b1;
        write_d = (pass_q == PASS_WRITE);
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // A completion in the expiry cycle takes priority over the timeout.
        if (bus_if.txn_done_i) begin
          if (pass_q == PASS_VERIFY && rd_data != exp_data && mm_cnt_q != 16'hFFFF) begin
            mm_cnt_d = mm_cnt_q + 16'd1;
          end
          if (HAS_SETTLE && pass_q == PASS_WRITE && idx_q == SETTLE_IDX) begin
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_NEXT;
          end
        end else if (timer_expired) begin
          error_d   = 1'b1;
          err_idx_d = idx_q;
          busy_d    = 1'b0;
          state_d   = ST_ERROR;
        end
      end
      ST_SETTLE: begin
        if (timer_expired) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (idx_q != LAST_IDX) begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_ISSUE;
        end else if (pass_q == PASS_WRITE && verify_q) begin
          idx_d   = '0;
          pass_d  = PASS_VERIFY;
          state_d = ST_ISSUE;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE, ST_ERROR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      pass_q    <= PASS_WRITE;
      verify_q  <= 1'b0;
      idx_q     <= '0;
      load_q    <= 1'b0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
      mm_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      pass_q    <= pass_d;
      verify_q  <= verify_d;
      idx_q     <= idx_d;
      load_q    <= load_d;
      write_q   <= write_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      err_idx_q <= err_idx_d;
      mm_cnt_q  <= mm_cnt_d;
    end
  end

  assign bus_if.load_o      = load_q;
  assign bus_if.write_o     = write_q;
  assign bus_if.entry_idx_o = idx_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign error_o            = error_q;
  assign err_idx_o          = err_idx_q;
  assign mismatch_cnt_o     = mm_cnt_q;

endmodule

// File: tb/tb_si5340_cfg_sequencer.sv
// Directed bench for si5340_cfg_sequencer with a small loader model answering a fixed delay after load_o.
`timescale 1ns/1ps
module tb_si5340_cfg_sequencer;

  localparam int NUM_ENTRIES    = 4;
  localparam int PREAMBLE_LEN   = 2;
  localparam int DELAY_CYCLES   = 10;
  localparam int TIMEOUT_CYCLES = 20;
  localparam int DATA_WIDTH     = 8;
  localparam int IDX_W          = 2;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic             verify_i = 1'b0;
  logic             busy_o, done_o, error_o;
  logic [IDX_W-1:0] err_idx_o;
  logic [15:0]      mismatch_cnt_o;

  si5340_cfg_sequencer_if #(.IDX_W(IDX_W), .DATA_W(DATA_WIDTH)) bus ();

  si5340_cfg_sequencer #(
    .NUM_ENTRIES    (NUM_ENTRIES),
    .PREAMBLE_LEN   (PREAMBLE_LEN),
    .DELAY_CYCLES   (DELAY_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .DATA_WIDTH     (DATA_WIDTH)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .verify_i       (verify_i),
    .bus_if         (bus),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .error_o        (error_o),
    .err_idx_o      (err_idx_o),
    .mismatch_cnt_o (mismatch_cnt_o)
  );

  initial forever #4 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Loader model state and event log (cycle numbers count negedges).
  int   cyc = 0;
  int   resp_delay = 5;
  int   silent_idx = -1;
  int   corrupt_idx = -1;
  int   ld_cyc[$];
  int   ld_idx[$];
  bit   ld_wr[$];
  int   start_cyc = 0;
  int   done_rise = 0;
  int   err_rise = 0;
  bit   pend = 1'b0;
  int   pend_cnt = 0;
  int   pend_idx = 0;
  bit   pend_wr = 1'b0;
  bit   done_prev = 1'b0;
  bit   err_prev = 1'b0;
  logic [7:0] exp_tab [4] = '{8'h11, 8'h22, 8'h55, 8'h77};

  initial begin : loader_model
    bus.txn_done_i = 1'b0;
    bus.rd_data_i  = '0;
    bus.exp_data_i = '0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.txn_done_i = 1'b0;
      if (start_i === 1'b1) start_cyc = cyc;
      if (done_o === 1'b1 && !done_prev) done_rise = cyc;
      if (error_o === 1'b1 && !err_prev) err_rise = cyc;
      done_prev = (done_o === 1'b1);
      err_prev  = (error_o === 1'b1);
      if (bus.load_o === 1'b1) begin
        ld_cyc.push_back(cyc);
        ld_idx.push_back(int'(bus.entry_idx_o));
        ld_wr.push_back(bus.write_o);
        if (int'(bus.entry_idx_o) != silent_idx) begin
          pend     = 1'b1;
          pend_cnt = resp_delay;
          pend_idx = int'(bus.entry_idx_o);
          pend_wr  = bus.write_o;
        end
      end else if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          pend           = 1'b0;
          bus.txn_done_i = 1'b1;
          bus.rd_data_i  = (!pend_wr && pend_idx == corrupt_idx) ? 8'hAA : exp_tab[pend_idx];
        end
      end
      bus.exp_data_i = exp_tab[bus.entry_idx_o];
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic setup(input int d, input int s, input int c);
    resp_delay  = d;
    silent_idx  = s;
    corrupt_idx = c;
    ld_cyc.delete();
    ld_idx.delete();
    ld_wr.delete();
  endtask

  task automatic pulse_start(input logic v);
    @(posedge clk); #1;
    start_i  = 1'b1;
    verify_i = v;
    @(posedge clk); #1;
    start_i  = 1'b0;
    verify_i = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int k = 0;
    while (done_o !== 1'b1 && error_o !== 1'b1 && k < 2000) begin
      tick(1);
      k++;
    end
    n_cmp++;
    if (k >= 2000) begin
      n_mis++;
      $display("FAIL %s_finish: no done/error after %0d cycles, required completion", name, k);
    end
    tick(3);
  endtask

  task automatic wait_loads(input int n, input string name);
    int k = 0;
    while (ld_cyc.size() < n && k < 500) begin
      tick(1);
      k++;
    end
    n_cmp++;
    if (ld_cyc.size() < n) begin
      n_mis++;
      $display("FAIL %s_loads_seen: got %0d loads, required %0d", name, ld_cyc.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    tick(1);
    n_cmp++;
    if ({bus.load_o, bus.write_o, bus.entry_idx_o, busy_o, done_o, error_o, err_idx_o} !== 9'd0) begin
      n_mis++;
      $display("FAIL reset_outputs: got %b, required 0", {bus.load_o, bus.write_o, bus.entry_idx_o, busy_o, done_o, error_o, err_idx_o});
    end
    n_cmp++;
    if (mismatch_cnt_o !== 16'd0) begin
      n_mis++;
      $display("FAIL reset_mismatch_cnt: got %0d, required 0", mismatch_cnt_o);
    end
  endtask

  task automatic test_write_only();
    int exp_gap [3] = '{8, 18, 8};
    setup(5, -1, -1);
    pulse_start(1'b0);
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_mis++;
      $display("FAIL wr_busy_after_start: got %b, required 1", busy_o);
    end
    wait_end("wr");
    n_cmp++;
    if (ld_cyc.size() != 4) begin
      n_mis++;
      $display("FAIL wr_load_count: got %0d, required 4", ld_cyc.size());
    end else begin
      n_cmp++;
      if (ld_cyc[0] - start_cyc != 2) begin
        n_mis++;
        $display("FAIL wr_start_latency: got %0d, required 2", ld_cyc[0] - start_cyc);
      end
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (ld_idx[i] != i || ld_wr[i] !== 1'b1) begin
          n_mis++;
          $display("FAIL wr_load%0d: got idx %0d write %b, required idx %0d write 1", i, ld_idx[i], ld_wr[i], i);
        end
      end
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (ld_cyc[i+1] - ld_cyc[i] != exp_gap[i]) begin
          n_mis++;
          $display("FAIL wr_gap%0d: got %0d, required %0d", i, ld_cyc[i+1] - ld_cyc[i], exp_gap[i]);
        end
      end
      n_cmp++;
      if (done_rise - ld_cyc[3] != 7) begin
        n_mis++;
        $display("FAIL wr_done_latency: got %0d, required 7", done_rise - ld_cyc[3]);
      end
    end
    n_cmp++;
    if ({done_o, busy_o, error_o} !== 3'b100) begin
      n_mis++;
      $display("FAIL wr_status: got done/busy/error %b, required 100", {done_o, busy_o, error_o});
    end
  endtask

  task automatic test_verify(input int corrupt, input logic [15:0] exp_mm, input string name);
    int exp_gap [7] = '{8, 18, 8, 8, 8, 8, 8};
    setup(5, -1, corrupt);
    pulse_start(1'b1);
    n_cmp++;
    if ({done_o, busy_o} !== 2'b01) begin
      n_mis++;
      $display("FAIL %s_start_clears_done: got done/busy %b, required 01", name, {done_o, busy_o});
    end
    wait_end(name);
    n_cmp++;
    if (ld_cyc.size() != 8) begin
      n_mis++;
      $display("FAIL %s_load_count: got %0d, required 8", name, ld_cyc.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (ld_idx[i] != i % 4 || ld_wr[i] !== (i < 4)) begin
          n_mis++;
          $display("FAIL %s_load%0d: got idx %0d write %b, required idx %0d write %b", name, i, ld_idx[i], ld_wr[i], i % 4, i < 4);
        end
      end
      for (int i = 0; i < 7; i++) begin
        n_cmp++;
        if (ld_cyc[i+1] - ld_cyc[i] != exp_gap[i]) begin
          n_mis++;
          $display("FAIL %s_gap%0d: got %0d, required %0d", name, i, ld_cyc[i+1] - ld_cyc[i], exp_gap[i]);
        end
      end
    end
    n_cmp++;
    if (mismatch_cnt_o !== exp_mm) begin
      n_mis++;
      $display("FAIL %s_mismatch_cnt: got %0d, required %0d", name, mismatch_cnt_o, exp_mm);
    end
    n_cmp++;
    if ({done_o, busy_o, error_o} !== 3'b100) begin
      n_mis++;
      $display("FAIL %s_status: got done/busy/error %b, required 100", name, {done_o, busy_o, error_o});
    end
  endtask

  task automatic test_timeout_boundary();
    // Completion in the expiry cycle (delay 19) must be accepted.
    setup(19, -1, -1);
    pulse_start(1'b0);
    n_cmp++;
    if (mismatch_cnt_o !== 16'd0) begin
      n_mis++;
      $display("FAIL bnd_start_clears_mismatch: got %0d, required 0", mismatch_cnt_o);
    end
    wait_end("bnd19");
    n_cmp++;
    if (ld_cyc.size() != 4) begin
      n_mis++;
      $display("FAIL bnd19_load_count: got %0d, required 4", ld_cyc.size());
    end else begin
      n_cmp++;
      if (ld_cyc[2] - ld_cyc[1] != 32 || done_rise - ld_cyc[3] != 21) begin
        n_mis++;
        $display("FAIL bnd19_timing: got settle gap %0d done latency %0d, required 32 and 21", ld_cyc[2] - ld_cyc[1], done_rise - ld_cyc[3]);
      end
    end
    n_cmp++;
    if ({done_o, error_o} !== 2'b10) begin
      n_mis++;
      $display("FAIL bnd19_status: got done/error %b, required 10", {done_o, error_o});
    end
    // One cycle later is too late: timeout on entry 0, and the late completion is ignored.
    setup(20, -1, -1);
    pulse_start(1'b0);
    wait_end("bnd20");
    tick(10);
    n_cmp++;
    if ({error_o, done_o, busy_o} !== 3'b100 || err_idx_o !== 2'd0) begin
      n_mis++;
      $display("FAIL bnd20_status: got error/done/busy %b err_idx %0d, required 100 and 0", {error_o, done_o, busy_o}, err_idx_o);
    end
    n_cmp++;
    if (ld_cyc.size() != 1 || err_rise - ld_cyc[0] != 20) begin
      n_mis++;
      $display("FAIL bnd20_timing: got %0d loads, error latency %0d, required 1 and 20", ld_cyc.size(), err_rise - ld_cyc[0]);
    end
  endtask

  task automatic test_timeout();
    setup(5, 1, -1);
    pulse_start(1'b0);
    wait_end("tmo");
    tick(40);
    n_cmp++;
    if ({error_o, done_o, busy_o} !== 3'b100) begin
      n_mis++;
      $display("FAIL tmo_status: got error/done/busy %b, required 100", {error_o, done_o, busy_o});
    end
    n_cmp++;
    if (err_idx_o !== 2'd1) begin
      n_mis++;
      $display("FAIL tmo_err_idx: got %0d, required 1", err_idx_o);
    end
    n_cmp++;
    if (ld_cyc.size() != 2) begin
      n_mis++;
      $display("FAIL tmo_load_count: got %0d, required 2", ld_cyc.size());
    end else begin
      n_cmp++;
      if (err_rise - ld_cyc[1] != 20) begin
        n_mis++;
        $display("FAIL tmo_latency: got %0d, required 20", err_rise - ld_cyc[1]);
      end
    end
  endtask

  task automatic test_reset_and_ignored_start();
    int n_ld;
    // Reset in the middle of SETTLE.
    setup(5, -1, -1);
    pulse_start(1'b0);
    wait_loads(2, "rst_settle");
    tick(8);
    n_cmp++;
    if ({busy_o, bus.load_o} !== 2'b10) begin
      n_mis++;
      $display("FAIL rst_settle_pre: got busy/load %b, required 10", {busy_o, bus.load_o});
    end
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    n_cmp++;
    if ({bus.load_o, bus.write_o, bus.entry_idx_o, busy_o, done_o, error_o, err_idx_o, mismatch_cnt_o} !== 25'd0) begin
      n_mis++;
      $display("FAIL rst_settle_outputs: got %b, required 0", {bus.load_o, bus.write_o, bus.entry_idx_o, busy_o, done_o, error_o, err_idx_o, mismatch_cnt_o});
    end
    n_ld = ld_cyc.size();
    tick(40);
    n_cmp++;
    if (ld_cyc.size() != n_ld || busy_o !== 1'b0) begin
      n_mis++;
      $display("FAIL rst_settle_quiet: got %0d loads busy %b, required %0d loads busy 0", ld_cyc.size(), busy_o, n_ld);
    end
    // Reset during WAIT_DONE; the loader's later txn_done_i must be ignored.
    setup(5, -1, -1);
    pulse_start(1'b0);
    wait_loads(1, "rst_wait");
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    tick(30);
    n_cmp++;
    if (ld_cyc.size() != 1 || {busy_o, done_o, error_o} !== 3'b000) begin
      n_mis++;
      $display("FAIL rst_wait_quiet: got %0d loads busy/done/error %b, required 1 and 000", ld_cyc.size(), {busy_o, done_o, error_o});
    end
    // start_i while busy is ignored (its verify_i=1 must not take effect).
    setup(5, -1, -1);
    pulse_start(1'b0);
    wait_loads(1, "ign");
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_mis++;
      $display("FAIL ign_busy: got %b, required 1", busy_o);
    end
    pulse_start(1'b1);
    wait_end("ign");
    n_cmp++;
    if (ld_cyc.size() != 4) begin
      n_mis++;
      $display("FAIL ign_load_count: got %0d, required 4", ld_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (ld_idx[i] != i || ld_wr[i] !== 1'b1) begin
          n_mis++;
          $display("FAIL ign_load%0d: got idx %0d write %b, required idx %0d write 1", i, ld_idx[i], ld_wr[i], i);
        end
      end
    end
    n_cmp++;
    if ({done_o, busy_o, error_o} !== 3'b100) begin
      n_mis++;
      $display("FAIL ign_status: got done/busy/error %b, required 100", {done_o, busy_o, error_o});
    end
  endtask

  initial begin
    test_reset();
    test_write_only();
    test_verify(-1, 16'd0, "vfy_ok");
    test_verify(2, 16'd1, "vfy_bad");
    test_timeout_boundary();
    test_timeout();
    test_reset_and_ignored_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/si5340_cfg_sequencer.md
Name: si5340_cfg_sequencer

Overview:
Upstream control stage for the Si5340 config loader. Walks the configuration table from entry 0 to NUM_ENTRIES-1 and issues one loader transaction per entry through a load/done handshake. Inserts the mandatory post-preamble settle delay after the preamble entries. Can optionally run a readback-verify pass after the write pass, and reports busy, done, timeout error and mismatch status to the system controller.

Parameters:
NUM_ENTRIES, 512, number of table entries to process (equals cfg_pkg MEM_DEPTH).
PREAMBLE_LEN, 3, number of leading preamble entries; settle delay is inserted after entry PREAMBLE_LEN-1.
DELAY_CYCLES, 37_500_000, settle delay in clk_i cycles (300 ms at 8 ns).
TIMEOUT_CYCLES, 1_000_000, maximum cycles from load_o to txn_done_i.
DATA_WIDTH, 8, register data width.

Ports:
clk_i  in  1  single system clock.
rst_i  in  1  synchronous, active-high reset.
start_i  in  1  pulse; begins a sequence when idle.
verify_i  in  1  sampled with start_i; 1 = run readback pass after writes.
load_o  out  1  one-cycle request to loader.
write_o  out  1  transaction type, valid with load_o; 1 = write, 0 = read.
entry_idx_o  out  $clog2(NUM_ENTRIES)  table index for current transaction; stable from load_o until txn_done_i.
txn_done_i  in  1  one-cycle pulse from loader: transaction finished.
rd_data_i  in  DATA_WIDTH  readback byte, valid when txn_done_i=1 during a read.
exp_data_i  in  DATA_WIDTH  expected data of table[entry_idx_o].
busy_o  out  1  sequence in progress.
done_o  out  1  level; sequence completed. Cleared by next accepted start_i.
error_o  out  1  level; transaction timeout. Cleared by next accepted start_i.
err_idx_o  out  $clog2(NUM_ENTRIES)  index of timed-out entry.
mismatch_cnt_o  out  16  readback mismatches, saturating at 16'hFFFF.

Behaviour:
- Reset (sync, rst_i=1 at posedge): state IDLE; load_o=0, write_o=0, entry_idx_o=0, busy_o=0, done_o=0, error_o=0, err_idx_o=0, mismatch_cnt_o=0, counters=0. Reset mid-transaction abandons it with no further load_o. A txn_done_i arriving later is ignored.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_DONE, SETTLE, NEXT, DONE, ERROR.
- IDLE: on start_i, latch verify_i, set pass=WRITE and entry_idx_o=0. Clear done_o, error_o and mismatch_cnt_o. Set busy_o=1 and go to ISSUE. start_i in any other state is ignored.
- ISSUE: load_o=1 for exactly one cycle, with write_o=1 for the write pass and 0 for the verify pass. Clear the timer and go to WAIT_DONE. Latency from start_i sampled to load_o high is 2 cycles.
- WAIT_DONE: the timer increments each cycle.
  - On txn_done_i in the verify pass, compare rd_data_i with exp_data_i. If they differ, increment mismatch_cnt_o (saturating).
  - If txn_done_i=1 and the pass is WRITE and entry_idx_o==PREAMBLE_LEN-1, go to SETTLE; otherwise go to NEXT.
  - If the timer reaches TIMEOUT_CYCLES-1 without txn_done_i, set error_o=1 and err_idx_o=entry_idx_o, then go to ERROR.
  - If txn_done_i and timer expiry occur in the same cycle, txn_done_i wins.
- SETTLE: count DELAY_CYCLES cycles, then go to NEXT. No load_o is issued during SETTLE. Skipped in the verify pass.
- NEXT:
  - If entry_idx_o < NUM_ENTRIES-1: increment entry_idx_o and go to ISSUE.
  - Else if pass=WRITE and verify is latched: set entry_idx_o=0, pass=VERIFY, go to ISSUE.
  - Else: go to DONE.
  - The index wraps to 0 only via these paths and never exceeds NUM_ENTRIES-1.
- DONE: busy_o=0, done_o=1. Return to IDLE in the next cycle; done_o holds.
- ERROR: busy_o=0, error_o=1. Return to IDLE in the next cycle; error_o and err_idx_o hold.
- Stray txn_done_i outside WAIT_DONE is ignored.
- Degenerate cases:
  - NUM_ENTRIES=1 is legal.
  - PREAMBLE_LEN=0 disables SETTLE.
  - PREAMBLE_LEN must be ≤ NUM_ENTRIES; this is checked with an elaboration assertion.

Decomposition:
- cfg_pkg holds:
  - seq_state_t enum;
  - pass_t enum (WRITE/VERIFY);
  - the DELAY_CYCLES and TIMEOUT_CYCLES defaults, derived from PERIOD_NS;
  - MEM_DEPTH and DATA_WIDTH.
- One sub-module, cfg_cycle_timer, with clear, enable, terminal-count input and expired output. A single instance is shared between SETTLE and WAIT_DONE, since they never overlap. Its width is $clog2(max(DELAY_CYCLES, TIMEOUT_CYCLES)).

Test Plan:
Bench parameters are NUM_ENTRIES=4, PREAMBLE_LEN=2, DELAY_CYCLES=10, TIMEOUT_CYCLES=20. The loader model answers txn_done_i 5 cycles after load_o.
1. Write pass only: start_i with verify_i=0 -> 4 load_o pulses with write_o=1 at idx 0,1,2,3. The gap after idx 1 is ≥10 cycles longer than the other gaps. Then done_o=1, busy_o=0, error_o=0.
2. Verify, matching data: start_i with verify_i=1, model returns rd_data_i=exp_data_i -> 4 write loads, then 4 read loads at idx 0..3 with no settle in the verify pass. Ends with done_o=1 and mismatch_cnt_o=0.
3. Verify, mismatch: model corrupts the read of idx 2 (rd_data=8'hAA, exp=8'h55) -> mismatch_cnt_o=1 and done_o=1.
4. Timeout: model never answers idx 1 -> error_o=1 and err_idx_o=1 exactly 20 cycles after that load_o. No further load_o; busy_o=0.
5. Timeout boundary: txn_done_i arrives in the same cycle as timer expiry -> no error, and the sequence continues.
6. Reset mid-SETTLE and ignored start: assert rst_i during SETTLE -> all outputs return to reset values and no load_o appears. Separately, start_i while busy_o=1 -> ignored and the sequence is unchanged.
